half_divide_arbiter: RTL and testbench

- Shares one pipelined half-precision divider among N requesters.
- Round-robin arbitration; at most one operation issued per cycle.
- Requester IDs tracked in an in-order tag FIFO; each quotient is routed back to the requester that issued it.
- Sits between the per-channel half-float compute lanes and the single half_divide instance.

---
 rtl/half_divide_arbiter_if.sv | 28 ++
 rtl/half_divide_arbiter.sv | 137 +++++++++++++
 tb/tb_half_divide_arbiter.sv | 271 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/half_divide_arbiter_if.sv
// Requester and divider bus for half_divide_arbiter.
// The master modport is the environment (compute lanes plus divider).
// The slave modport is the arbiter.
interface half_divide_arbiter_if #(
  parameter int N = 4
);
  logic [N-1:0]    req_valid;
  logic [16*N-1:0] req_a;
  logic [16*N-1:0] req_b;
  logic [N-1:0]    req_ready;
  logic            div_in_valid;
  logic [15:0]     div_a;
  logic [15:0]     div_b;
  logic            div_out_valid;
  logic [15:0]     div_c;
  logic [N-1:0]    rsp_valid;
  logic [15:0]     rsp_c;

  modport master (
    output req_valid, req_a, req_b, div_out_valid, div_c,
    input  req_ready, div_in_valid, div_a, div_b, rsp_valid, rsp_c
  );

  modport slave (
    input  req_valid, req_a, req_b, div_out_valid, div_c,
    output req_ready, div_in_valid, div_a, div_b, rsp_valid, rsp_c
  );
endinterface

// File: rtl/half_divide_arbiter.sv
// Round-robin front end that shares one pipelined half-precision divider
// among N requesters.
// Each accepted request pushes the requester ID into an in-order tag FIFO.
// Each divider result pops the FIFO, so the quotient goes back to the
// requester that issued the operation.
module half_divide_arbiter #(
  parameter int N     = 4,
  parameter int DEPTH = 32,
  parameter int IDW   = 3
) (
  input  logic                  clk,
  input  logic                  rstn,
  half_divide_arbiter_if.slave  bus,
  output logic [IDW+2:0]        outstanding,
  output logic                  busy,
  output logic                  err
);
  localparam int AW = $clog2(DEPTH);
  localparam int CW = IDW + 3;

  logic [IDW-1:0] ptr_q, ptr_d;
  logic [AW-1:0]  wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [IDW-1:0] mem_q [DEPTH];
  logic [IDW-1:0] mem_d [DEPTH];
  logic           div_in_valid_q, div_in_valid_d;
  logic [15:0]    div_a_q, div_a_d, div_b_q, div_b_d;
  logic [N-1:0]   rsp_valid_q, rsp_valid_d;
  logic [15:0]    rsp_c_q, rsp_c_d;
  logic           err_q, err_d;
  logic           busy_q, busy_d;

  logic           hit_s, grant_found_s, can_issue_s, push_s, pop_s, underflow_s;
  logic [IDW-1:0] grant_idx_s, head_id_s;
  logic [N-1:0]   ready_s;
  logic [15:0]    grant_a_s, grant_b_s;

  // Round-robin search starting just after the last granted requester.
  always_comb begin
    hit_s         = 1'b0;
    grant_found_s = 1'b0;
    grant_idx_s   = '0;
    for (int k = 1; k <= N; k++) begin
      for (int i = 0; i < N; i++) begin
        hit_s         = !grant_found_s && bus.req_valid[i] && (((int'(ptr_q) + k) % N) == i);
        grant_idx_s   = hit_s ? IDW'(i) : grant_idx_s;
        grant_found_s = grant_found_s | hit_s;
      end
    end
  end

  // Accept/pop decisions, the one-hot ready and the granted operand mux.
  // A full FIFO blocks accepts even when a pop lands in the same cycle.
  always_comb begin
    can_issue_s = (cnt_q < CW'(DEPTH));
    push_s      = can_issue_s & grant_found_s;
    head_id_s   = mem_q[rd_ptr_q];
    pop_s       = bus.div_out_valid && (cnt_q != '0);
    underflow_s = bus.div_out_valid && (cnt_q == '0);
    ready_s     = '0;
    grant_a_s   = 16'h0000;
    grant_b_s   = 16'h0000;
    for (int i = 0; i < N; i++) begin
      ready_s[i] = push_s && (grant_idx_s == IDW'(i));
      grant_a_s  = (grant_idx_s == IDW'(i)) ? bus.req_a[16*i +: 16] : grant_a_s;
      grant_b_s  = (grant_idx_s == IDW'(i)) ? bus.req_b[16*i +: 16] : grant_b_s;
    end
  end

  // Next-state for the pointers, occupancy, tag storage and output registers.
  always_comb begin
    mem_d = mem_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = grant_idx_s;
    end else begin
      mem_d[wr_ptr_q] = mem_q[wr_ptr_q];
    end
    ptr_d    = push_s ? grant_idx_s : ptr_q;
    wr_ptr_d = push_s ? (wr_ptr_q + AW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + AW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   cnt_d = cnt_q + CW'(1);
      2'b01:   cnt_d = cnt_q - CW'(1);
      default: cnt_d = cnt_q;
    endcase
    div_in_valid_d = push_s;
    div_a_d        = push_s ? grant_a_s : div_a_q;
    div_b_d        = push_s ? grant_b_s : div_b_q;
    for (int i = 0; i < N; i++) begin
      rsp_valid_d[i] = pop_s && (head_id_s == IDW'(i));
    end
    rsp_c_d = pop_s ? bus.div_c : rsp_c_q;
    err_d   = err_q | underflow_s;
    busy_d  = (cnt_d != '0);
  end

  // State registers with synchronous active-low reset.
  always_ff @(posedge clk) begin
    if (!rstn) begin
      ptr_q          <= IDW'(N - 1);
      wr_ptr_q       <= '0;
      rd_ptr_q       <= '0;
      cnt_q          <= '0;
      mem_q          <= '{default: '0};
      div_in_valid_q <= 1'b0;
      div_a_q        <= 16'h0000;
      div_b_q        <= 16'h0000;
      rsp_valid_q    <= '0;
      rsp_c_q        <= 16'h0000;
      err_q          <= 1'b0;
      busy_q         <= 1'b0;
    end else begin
      ptr_q          <= ptr_d;
      wr_ptr_q       <= wr_ptr_d;
      rd_ptr_q       <= rd_ptr_d;
      cnt_q          <= cnt_d;
      mem_q          <= mem_d;
      div_in_valid_q <= div_in_valid_d;
      div_a_q        <= div_a_d;
      div_b_q        <= div_b_d;
      rsp_valid_q    <= rsp_valid_d;
      rsp_c_q        <= rsp_c_d;
      err_q          <= err_d;
      busy_q         <= busy_d;
    end
  end

  assign bus.req_ready    = ready_s;
  assign bus.div_in_valid = div_in_valid_q;
  assign bus.div_a        = div_a_q;
  assign bus.div_b        = div_b_q;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_c        = rsp_c_q;
  assign outstanding      = cnt_q;
  assign busy             = busy_q;
  assign err              = err_q;
endmodule

// File: tb/tb_half_divide_arbiter.sv
// Scoreboard bench for half_divide_arbiter.
// The stimulus pushes the expected issue and response for each accept it
// predicts. Negedge monitors pop and compare whenever the DUT strobes.
// A small queue-based divider stand-in returns hand-tabulated quotients.
`timescale 1ns/1ps
module tb_half_divide_arbiter;
  localparam int N = 4, DEPTH = 32, IDW = 3, LAT = 4;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  half_divide_arbiter_if #(.N(N)) bus();
  logic [IDW+2:0] outstanding;
  logic busy, err;

  half_divide_arbiter #(.N(N), .DEPTH(DEPTH), .IDW(IDW)) dut (
    .clk(clk), .rstn(rstn), .bus(bus),
    .outstanding(outstanding), .busy(busy), .err(err)
  );

  // Per-requester operands and hand-computed quotients.
  // 1/2 = 0.5, 5/1 = 5, 6/3 = 2, 8/2 = 4.
  logic [15:0] a_tab [N] = '{16'h3C00, 16'h4500, 16'h4600, 16'h4800};
  logic [15:0] b_tab [N] = '{16'h4000, 16'h3C00, 16'h4200, 16'h4000};
  logic [15:0] c_tab [N] = '{16'h3800, 16'h4500, 16'h4000, 16'h4400};

  typedef struct { int id; logic [15:0] c; } rsp_t;
  typedef struct { logic [15:0] c; int due; } dop_t;

  rsp_t        rsp_q[$];
  logic [31:0] iss_q[$];
  dop_t        dq[$];
  int          nchk = 0, nerr = 0, cyc = 0, rel = 0;
  logic        stall = 1'b0, inj_req = 1'b0, flush_req = 1'b0;
  logic [31:0] exp_ab;
  rsp_t        exp_r;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    nchk++;
    if (act !== exp) begin
      nerr++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [15:0] fake_div(input logic [15:0] a, input logic [15:0] b);
    case ({a, b})
      32'h3C00_4000: return 16'h3800;
      32'h4500_3C00: return 16'h4500;
      32'h4600_4200: return 16'h4000;
      32'h4800_4000: return 16'h4400;
      default:       return 16'hDEAD;
    endcase
  endfunction

  always @(posedge clk) cyc++;

  // Divider stand-in: fixed latency, in order, can be stalled, released
  // one result at a time, flushed, or forced to emit a spurious result.
  always @(negedge clk) begin
    if (flush_req) begin
      dq.delete();
      flush_req = 1'b0;
    end
    if (bus.div_in_valid === 1'b1) dq.push_back('{fake_div(bus.div_a, bus.div_b), cyc + LAT - 1});
    if (inj_req) begin
      bus.div_out_valid = 1'b1;
      bus.div_c         = 16'h1234;
      inj_req           = 1'b0;
    end else if (dq.size() > 0 && dq[0].due <= cyc && (!stall || rel > 0)) begin
      bus.div_out_valid = 1'b1;
      bus.div_c         = dq[0].c;
      void'(dq.pop_front());
      if (stall && rel > 0) rel--;
    end else begin
      bus.div_out_valid = 1'b0;
    end
  end

  // Monitors: compare every issue and every response against the queues.
  always @(negedge clk) begin
    if (rstn) begin
      if (bus.div_in_valid === 1'b1) begin
        if (iss_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL issue_unexpected: got a=%h b=%h expected no issue", bus.div_a, bus.div_b);
        end else begin
          exp_ab = iss_q.pop_front();
          chk("div_a", 32'(bus.div_a), 32'(exp_ab[31:16]));
          chk("div_b", 32'(bus.div_b), 32'(exp_ab[15:0]));
        end
      end
      if (bus.rsp_valid !== 4'b0000) begin
        if (rsp_q.size() == 0) begin
          nchk++; nerr++;
          $display("FAIL rsp_unexpected: got rsp_valid=%b c=%h expected none", bus.rsp_valid, bus.rsp_c);
        end else begin
          exp_r = rsp_q.pop_front();
          chk("rsp_valid", 32'(bus.rsp_valid), 32'(1) << exp_r.id);
          chk("rsp_c", 32'(bus.rsp_c), 32'(exp_r.c));
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic expect_ready(input logic [N-1:0] exp_rdy);
    @(negedge clk);
    chk("req_ready", 32'(bus.req_ready), 32'(exp_rdy));
    for (int i = 0; i < N; i++) begin
      if (exp_rdy[i]) begin
        iss_q.push_back({a_tab[i], b_tab[i]});
        rsp_q.push_back('{i, c_tab[i]});
      end
    end
  endtask

  task automatic step(input logic [N-1:0] exp_rdy);
    expect_ready(exp_rdy);
    tick();
  endtask

  task automatic drain();
    int t;
    t = 0;
    bus.req_valid = '0;
    stall = 1'b0;
    while ((rsp_q.size() != 0 || iss_q.size() != 0 || dq.size() != 0) && t < 300) begin
      tick();
      t++;
    end
    chk("drain_done", 32'(t < 300), 32'd1);
    @(negedge clk);
    chk("drain_outstanding", 32'(outstanding), 32'd0);
    chk("drain_busy", 32'(busy), 32'd0);
    tick();
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got no finish expected finish within time limit");
    $fatal(1);
  end

  initial begin
    bus.req_valid     = '0;
    bus.div_out_valid = 1'b0;
    bus.div_c         = 16'h0000;
    for (int i = 0; i < N; i++) begin
      bus.req_a[16*i +: 16] = a_tab[i];
      bus.req_b[16*i +: 16] = b_tab[i];
    end

    // Reset state
    rstn = 1'b0;
    repeat (2) tick();
    @(negedge clk);
    chk("rst_div_in_valid", 32'(bus.div_in_valid), 32'd0);
    chk("rst_div_a", 32'(bus.div_a), 32'd0);
    chk("rst_div_b", 32'(bus.div_b), 32'd0);
    chk("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("rst_rsp_c", 32'(bus.rsp_c), 32'd0);
    chk("rst_err", 32'(err), 32'd0);
    chk("rst_outstanding", 32'(outstanding), 32'd0);
    chk("rst_busy", 32'(busy), 32'd0);
    tick();
    rstn = 1'b1;

    // Single request from requester 2: 6.0 / 3.0
    bus.req_valid = 4'b0100;
    step(4'b0100);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("single_issue_next_cycle", 32'(bus.div_in_valid), 32'd1);
    tick();
    drain();

    // Round robin with all requesters valid straight out of reset
    bus.req_valid = 4'b1111;
    rstn = 1'b0;
    tick();
    rstn = 1'b1;
    step(4'b0001); step(4'b0010); step(4'b0100);
    step(4'b1000); step(4'b0001); step(4'b0010);
    drain();

    // Partial load: only requesters 1 and 3 request
    bus.req_valid = 4'b1010;
    step(4'b1000); step(4'b0010); step(4'b1000); step(4'b0010);
    drain();

    // Full boundary with the divider stalled
    stall = 1'b1;
    bus.req_valid = 4'b0001;
    repeat (DEPTH) step(4'b0001);
    @(negedge clk);
    chk("full_ready", 32'(bus.req_ready), 32'd0);
    chk("full_outstanding", 32'(outstanding), 32'd32);
    chk("full_busy", 32'(busy), 32'd1);
    tick();
    rel = 1;
    step(4'b0000);
    expect_ready(4'b0001);
    chk("after_pop_outstanding", 32'(outstanding), 32'd31);
    tick();
    @(negedge clk);
    chk("refill_outstanding", 32'(outstanding), 32'd32);
    tick();
    drain();

    // Simultaneous push and pop at occupancy 5
    stall = 1'b1;
    bus.req_valid = 4'b0001;
    repeat (5) step(4'b0001);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("occ5_outstanding", 32'(outstanding), 32'd5);
    tick();
    bus.req_valid = 4'b0001;
    rel = 1;
    step(4'b0001);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("pushpop_outstanding", 32'(outstanding), 32'd5);
    tick();
    drain();

    // Underflow: a result arrives with an empty FIFO
    inj_req = 1'b1;
    @(negedge clk);
    @(negedge clk);
    chk("underflow_err", 32'(err), 32'd1);
    chk("underflow_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    chk("underflow_rsp_c_hold", 32'(bus.rsp_c), 32'h3800);
    chk("underflow_outstanding", 32'(outstanding), 32'd0);
    repeat (3) @(negedge clk);
    chk("err_sticky", 32'(err), 32'd1);
    tick();

    // Reset with three operations outstanding
    stall = 1'b1;
    bus.req_valid = 4'b0100;
    repeat (3) step(4'b0100);
    bus.req_valid = 4'b0000;
    @(negedge clk);
    chk("pre_reset_outstanding", 32'(outstanding), 32'd3);
    tick();
    rstn = 1'b0;
    flush_req = 1'b1;
    stall = 1'b0;
    rsp_q.delete();
    tick();
    rstn = 1'b1;
    @(negedge clk);
    chk("post_reset_outstanding", 32'(outstanding), 32'd0);
    chk("post_reset_err", 32'(err), 32'd0);
    chk("post_reset_busy", 32'(busy), 32'd0);
    chk("post_reset_rsp_valid", 32'(bus.rsp_valid), 32'd0);
    tick();
    bus.req_valid = 4'b1111;
    step(4'b0001);
    drain();

    $display("== %0d vectors applied, %0d miscompares ==", nchk, nerr);
    $finish;
  end
endmodule
